// File: rtl/sd_fifo_pkg.sv
// Shared types and default parameters for the SD burst FIFO.
// Burst FSM states plus the default geometry of one 512-byte SD block.
package sd_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } burst_state_e;

  localparam int DEF_DW          = 16;
  localparam int DEF_AW          = 9;
  localparam int DEF_BURST_LEN   = 256;
  localparam int DEF_PF_TH       = 448;
  localparam int DEF_PE_TH       = 64;
  localparam int DEF_TOTAL_WORDS = 65536;

endpackage

// File: rtl/sd_burst_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous registered read port.
// Only the read register is reset/cleared; the array itself holds no reset.
module sdp_ram #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read register only advances on a read, so it holds its word while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_burst_fifo.sv
// Sample FIFO that drains in fixed-length bursts sized to one SD block,
// with level flags, sticky error flags and an accepted-write milestone flag.
module sd_burst_fifo
  import sd_fifo_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int PF_TH       = DEF_PF_TH,
  parameter int PE_TH       = DEF_PE_TH,
  parameter int TOTAL_WORDS = DEF_TOTAL_WORDS
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          burst_req,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          burst_busy,
  output logic          burst_done,
  output logic          burst_err,
  output logic          full,
  output logic          empty,
  output logic          prog_full,
  output logic          prog_empty,
  output logic          overflow,
  output logic [AW:0]   count,
  output logic          wr_finish
);

  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_C     = (AW+1)'(1 << AW);
  localparam logic [AW:0]   BURST_LEN_C = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]   PF_C        = (AW+1)'(PF_TH);
  localparam logic [AW:0]   PE_C        = (AW+1)'(PE_TH);
  localparam logic [31:0]   TOTAL_C     = 32'(TOTAL_WORDS);

  burst_state_e  state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d, remaining_q;
  logic          rd_valid_q, burst_busy_q, burst_done_q, burst_err_q;
  logic          overflow_q, wr_finish_q;
  logic [31:0]   wr_cnt_q;
  logic          wr_acc, pop;

  assign wr_acc = wr_en && (count_q != DEPTH_C) && !flush;
  // A pop refills the output register whenever it is empty or being consumed this cycle.
  assign pop = !flush && (state_q == BURST) && (remaining_q != '0) && (!rd_valid_q || rd_ready);

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      wr_cnt_q    <= '0;
      wr_finish_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      wr_cnt_q    <= '0;
      wr_finish_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      if (wr_en && (count_q == DEPTH_C)) begin
        overflow_q <= 1'b1;
      end
      if (wr_acc && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      // Flag trails the counter by one cycle; a zero target disables it.
      if ((TOTAL_C != '0) && (wr_cnt_q >= TOTAL_C)) begin
        wr_finish_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      rd_valid_q   <= 1'b0;
      burst_busy_q <= 1'b0;
      burst_done_q <= 1'b0;
      burst_err_q  <= 1'b0;
    end else if (flush) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      rd_valid_q   <= 1'b0;
      burst_busy_q <= 1'b0;
      burst_done_q <= 1'b0;
      burst_err_q  <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (burst_req) begin
            if (count_q >= BURST_LEN_C) begin
              state_q      <= BURST;
              remaining_q  <= BURST_LEN_C;
              burst_busy_q <= 1'b1;
            end else begin
              burst_err_q <= 1'b1;
            end
          end
        end
        BURST: begin
          if (pop) begin
            remaining_q <= remaining_q - CNT_ONE;
            rd_valid_q  <= 1'b1;
          end else if (rd_ready) begin
            rd_valid_q <= 1'b0;
          end
          // Burst ends only once the last word has actually left the output register.
          if ((remaining_q == '0) && rd_valid_q && rd_ready) begin
            state_q      <= DONE;
            burst_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          burst_busy_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          burst_busy_q <= 1'b0;
        end
      endcase
    end
  end

  sdp_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_i   (clk_50m),
    .rst_ni  (rst_n),
    .clr_i   (flush),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid   = rd_valid_q;
  assign burst_busy = burst_busy_q;
  assign burst_done = burst_done_q;
  assign burst_err  = burst_err_q;
  assign overflow   = overflow_q;
  assign wr_finish  = wr_finish_q;
  assign count      = count_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign prog_full  = (count_q >= PF_C);
  assign prog_empty = (count_q <= PE_C);

endmodule

// File: tb/tb_sd_burst_fifo.sv
// Self-checking bench for sd_burst_fifo: random data against a queue-based
// reference model, one task per scenario.
module tb_sd_burst_fifo;

  localparam int DW          = 16;
  localparam int AW          = 9;
  localparam int DEPTH       = 1 << AW;
  localparam int BURST_LEN   = 256;
  localparam int PF_TH       = 448;
  localparam int PE_TH       = 64;
  localparam int TOTAL_WORDS = 600;
  localparam logic [DW+AW+11:0] RESET_VEC =
    {1'b0, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {(AW+1){1'b0}}, 1'b0};

  logic          clk_50m = 1'b0;
  logic          rst_n, flush, wr_en, burst_req, rd_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, burst_busy, burst_done, burst_err;
  logic          full, empty, prog_full, prog_empty, overflow, wr_finish;
  logic [AW:0]   count;

  int            totalChecks = 0;
  int            badChecks   = 0;
  logic [DW-1:0] modelQ[$];
  int            wordsWritten = 0;
  bit            expOverflow  = 1'b0;
  logic [DW+AW+11:0] obsVec;

  always #10 clk_50m = ~clk_50m;

  sd_burst_fifo #(
    .DW(DW), .AW(AW), .BURST_LEN(BURST_LEN), .PF_TH(PF_TH),
    .PE_TH(PE_TH), .TOTAL_WORDS(TOTAL_WORDS)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .burst_req  (burst_req),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .burst_busy (burst_busy),
    .burst_done (burst_done),
    .burst_err  (burst_err),
    .full       (full),
    .empty      (empty),
    .prog_full  (prog_full),
    .prog_empty (prog_empty),
    .overflow   (overflow),
    .count      (count),
    .wr_finish  (wr_finish)
  );

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    modelQ.delete();
    wordsWritten = 0;
    expOverflow  = 1'b0;
  endtask

  // Idle-time writes; the model refuses words once it holds a full memory.
  task automatic writeWords(input int n, input bit sequential, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = sequential ? DW'(base + i) : DW'($urandom);
      if (modelQ.size() < DEPTH) begin
        modelQ.push_back(wr_data);
        wordsWritten++;
      end else begin
        expOverflow = 1'b1;
      end
      step();
    end
    wr_en = 1'b0;
  endtask

  // readyMode: 0 always ready, 1 toggling 1,0, 2 random. wrCount words are written during the burst.
  task automatic runBurst(input int readyMode, input int wrCount);
    int  xfers, firstXfer, lastXfer, wrDone, startSize;
    bit  stallPending;
    xfers = 0; firstXfer = -1; lastXfer = -1; wrDone = 0; stallPending = 1'b0;
    burst_req = 1'b1;
    step();
    burst_req = 1'b0;
    startSize = modelQ.size();
    totalChecks++;
    if (burst_busy !== 1'b1 || rd_valid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL burst_start: busy=%b valid=%b required busy=1 valid=0", burst_busy, rd_valid);
    end
    for (int it = 0; it < 4*BURST_LEN + 20 && xfers < BURST_LEN; it++) begin
      if (stallPending) begin
        totalChecks++;
        if (rd_valid !== 1'b1) begin
          badChecks++;
          $display("[TB] FAIL stall_hold_valid: got %b required 1", rd_valid);
        end
        stallPending = 1'b0;
      end
      if (it == 100 && wrCount > 100) begin
        totalChecks++;
        if (count !== (AW+1)'(startSize)) begin
          badChecks++;
          $display("[TB] FAIL steady_count: got %0d required %0d", count, startSize);
        end
      end
      if (rd_valid === 1'b1) begin
        totalChecks++;
        if (modelQ.size() == 0 || rd_data !== modelQ[0]) begin
          badChecks++;
          $display("[TB] FAIL rd_data: got %0h required %0h", rd_data,
                   (modelQ.size() == 0) ? 'x : modelQ[0]);
        end
      end
      case (readyMode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (it % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      burst_req = (it == 5);
      if (rd_valid === 1'b1 && rd_ready) begin
        if (modelQ.size() != 0) void'(modelQ.pop_front());
        if (firstXfer < 0) firstXfer = it;
        lastXfer = it;
        xfers++;
      end else if (rd_valid === 1'b1) begin
        stallPending = 1'b1;
      end
      if (wrDone < wrCount) begin
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        modelQ.push_back(wr_data);
        wrDone++;
        wordsWritten++;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0; burst_req = 1'b0; rd_ready = 1'b0;
    totalChecks++;
    if (xfers != BURST_LEN) begin
      badChecks++;
      $display("[TB] FAIL burst_timeout: transferred %0d required %0d", xfers, BURST_LEN);
    end
    totalChecks++;
    if (burst_done !== 1'b1 || burst_busy !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL done_pulse: done=%b busy=%b required 1 1", burst_done, burst_busy);
    end
    if (readyMode == 0) begin
      totalChecks++;
      if (lastXfer - firstXfer + 1 != BURST_LEN) begin
        badChecks++;
        $display("[TB] FAIL throughput: span %0d cycles required %0d", lastXfer - firstXfer + 1, BURST_LEN);
      end
    end
    step();
    totalChecks++;
    if (burst_done !== 1'b0 || burst_busy !== 1'b0 || rd_valid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL after_done: done=%b busy=%b valid=%b required 0 0 0", burst_done, burst_busy, rd_valid);
    end
    totalChecks++;
    if (count !== (AW+1)'(modelQ.size()) || burst_err !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL burst_end_state: count=%0d err=%b required %0d 0", count, burst_err, modelQ.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; burst_req = 1'b0; rd_ready = 1'b0;
    #5;
    obsVec = {rd_valid, rd_data, burst_busy, burst_done, burst_err, full, empty,
              prog_full, prog_empty, overflow, count, wr_finish};
    totalChecks++;
    if (obsVec !== RESET_VEC) begin
      badChecks++;
      $display("[TB] FAIL reset_values: got %h required %h", obsVec, RESET_VEC);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_burst();
    writeWords(BURST_LEN, 1'b1, 0);
    totalChecks++;
    if (count !== (AW+1)'(BURST_LEN)) begin
      badChecks++;
      $display("[TB] FAIL fill_count: got %0d required %0d", count, BURST_LEN);
    end
    runBurst(0, 0);
    totalChecks++;
    if (count !== '0 || empty !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL drained: count=%0d empty=%b required 0 1", count, empty);
    end
  endtask

  task automatic test_stalled_burst();
    doFlush();
    writeWords(300, 1'b0, 0);
    runBurst(1, 0);
    totalChecks++;
    if (count !== (AW+1)'(300 - BURST_LEN)) begin
      badChecks++;
      $display("[TB] FAIL stalled_count: got %0d required %0d", count, 300 - BURST_LEN);
    end
  endtask

  task automatic test_levels_overflow();
    int steps[6] = '{64, 1, 382, 1, 64, 1};
    doFlush();
    foreach (steps[k]) begin
      writeWords(steps[k], 1'b0, 0);
      totalChecks++;
      if (count !== (AW+1)'(modelQ.size()) || full !== (modelQ.size() == DEPTH) ||
          prog_full !== (modelQ.size() >= PF_TH) || prog_empty !== (modelQ.size() <= PE_TH) ||
          overflow !== expOverflow) begin
        badChecks++;
        $display("[TB] FAIL levels: count=%0d full=%b pf=%b pe=%b ovf=%b required count=%0d ovf=%b",
                 count, full, prog_full, prog_empty, overflow, modelQ.size(), expOverflow);
      end
    end
    runBurst(2, 0);
  endtask

  task automatic test_burst_err();
    doFlush();
    writeWords(100, 1'b0, 0);
    burst_req = 1'b1;
    step();
    burst_req = 1'b0;
    step();
    step();
    totalChecks++;
    if (burst_err !== 1'b1 || burst_busy !== 1'b0 || rd_valid !== 1'b0 || count !== 10'd100) begin
      badChecks++;
      $display("[TB] FAIL reject_100: err=%b busy=%b valid=%b count=%0d required 1 0 0 100",
               burst_err, burst_busy, rd_valid, count);
    end
    doFlush();
    totalChecks++;
    if (burst_err !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL flush_clears_err: got %b required 0", burst_err);
    end
    writeWords(BURST_LEN - 1, 1'b0, 0);
    burst_req = 1'b1;
    step();
    burst_req = 1'b0;
    totalChecks++;
    if (burst_err !== 1'b1 || burst_busy !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reject_boundary: err=%b busy=%b required 1 0", burst_err, burst_busy);
    end
    doFlush();
    writeWords(BURST_LEN, 1'b0, 0);
    runBurst(2, 0);
  endtask

  task automatic test_wrap();
    doFlush();
    writeWords(300, 1'b0, 0);
    runBurst(0, 250);
    totalChecks++;
    if (wr_finish !== (wordsWritten >= TOTAL_WORDS)) begin
      badChecks++;
      $display("[TB] FAIL wr_finish_early: got %b required %b", wr_finish, wordsWritten >= TOTAL_WORDS);
    end
    runBurst(2, 50);
    step();
    totalChecks++;
    if (wr_finish !== (wordsWritten >= TOTAL_WORDS) || count !== (AW+1)'(modelQ.size())) begin
      badChecks++;
      $display("[TB] FAIL wrap_end: wr_finish=%b count=%0d required %b %0d",
               wr_finish, count, wordsWritten >= TOTAL_WORDS, modelQ.size());
    end
  endtask

  task automatic test_abort_mid_burst();
    bit doneSeen;
    doFlush();
    writeWords(300, 1'b0, 0);
    burst_req = 1'b1; step(); burst_req = 1'b0;
    rd_ready = 1'b1;
    repeat (20) step();
    #5;
    rst_n = 1'b0;
    #1;
    obsVec = {rd_valid, rd_data, burst_busy, burst_done, burst_err, full, empty,
              prog_full, prog_empty, overflow, count, wr_finish};
    totalChecks++;
    if (obsVec !== RESET_VEC) begin
      badChecks++;
      $display("[TB] FAIL reset_mid_burst: got %h required %h", obsVec, RESET_VEC);
    end
    step(); step();
    rst_n = 1'b1;
    modelQ.delete(); wordsWritten = 0; expOverflow = 1'b0;
    doneSeen = 1'b0;
    repeat (300) begin
      step();
      if (burst_done === 1'b1 || burst_busy === 1'b1) doneSeen = 1'b1;
    end
    totalChecks++;
    if (doneSeen !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_no_done: got %b required 0", doneSeen);
    end

    writeWords(DEPTH + 1, 1'b0, 0);
    burst_req = 1'b1; step(); burst_req = 1'b0;
    repeat (20) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    modelQ.delete(); wordsWritten = 0; expOverflow = 1'b0;
    obsVec = {rd_valid, rd_data, burst_busy, burst_done, burst_err, full, empty,
              prog_full, prog_empty, overflow, count, wr_finish};
    totalChecks++;
    if (obsVec !== RESET_VEC) begin
      badChecks++;
      $display("[TB] FAIL flush_mid_burst: got %h required %h", obsVec, RESET_VEC);
    end
    doneSeen = 1'b0;
    repeat (300) begin
      step();
      if (burst_done === 1'b1 || burst_busy === 1'b1 || rd_valid === 1'b1) doneSeen = 1'b1;
    end
    totalChecks++;
    if (doneSeen !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL flush_no_done: got %b required 0", doneSeen);
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_stalled_burst();
    test_levels_overflow();
    test_burst_err();
    test_wrap();
    test_abort_mid_burst();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sd_burst_fifo.md
SD_BURST_FIFO -- requirements
Module: sd_burst_fifo

Interface
REQ-001 The module SHALL have parameter DW, default 16, sample/data word width.
REQ-002 The module SHALL have parameter AW, default 9, address width; depth = 2**AW words.
REQ-003 The module SHALL have parameter BURST_LEN, default 256, words per read burst (one 512-byte SD block); 1..2**AW.
REQ-004 The module SHALL have parameter PF_TH, default 448, prog_full threshold in words.
REQ-005 The module SHALL have parameter PE_TH, default 64, prog_empty threshold in words.
REQ-006 The module SHALL have parameter TOTAL_WORDS, default 65536, accepted-write count that raises wr_finish; 0 disables wr_finish.
REQ-007 The module SHALL have one clock and an asynchronous, active-low reset: ports clk_50m and rst_n.
REQ-008 The ports SHALL be:
- clk_50m  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  synchronous clear of contents, flags and counters
- wr_en  in  1  write strobe
- wr_data  in  DW  write word
- burst_req  in  1  single-cycle burst start request
- rd_ready  in  1  consumer ready
- rd_valid  out  1  rd_data valid
- rd_data  out  DW  read word
- burst_busy  out  1  burst in progress
- burst_done  out  1  one-cycle pulse after last burst word transfers
- burst_err  out  1  sticky: burst_req rejected
- full  out  1  count == 2**AW
- empty  out  1  count == 0
- prog_full  out  1  count >= PF_TH
- prog_empty  out  1  count <= PE_TH
- overflow  out  1  sticky: write dropped
- count  out  AW+1  stored words, excluding the output register
- wr_finish  out  1  sticky: TOTAL_WORDS writes accepted

Function
REQ-009 Write accepted iff wr_en && !full && !flush; a write while full SHALL be dropped and SHALL set overflow, even with a concurrent pop.
REQ-010 Storage SHALL be circular; pointers SHALL wrap from 2**AW-1 to 0.
REQ-011 count SHALL be +1 on write only, -1 on pop only, unchanged on both; full, empty, prog_full and prog_empty SHALL be combinational from the registered count.
REQ-012 FSM states SHALL be IDLE, BURST, DONE.
REQ-013 IDLE: burst_req with count >= BURST_LEN SHALL go to BURST and load remaining = BURST_LEN; burst_req with count < BURST_LEN SHALL set burst_err and stay IDLE.
REQ-014 BURST: a pop SHALL occur when remaining > 0 && (!rd_valid || rd_ready); rd_data/rd_valid SHALL be registered, so latency is 1 cycle from pop to rd_valid.
REQ-015 rd_data SHALL be held stable while rd_valid && !rd_ready; rd_valid SHALL be 0 outside BURST.
REQ-016 When remaining == 0 and the final word transfers (rd_valid && rd_ready), the FSM SHALL enter DONE; DONE SHALL assert burst_done for one cycle and return to IDLE.
REQ-017 burst_busy SHALL be 1 in BURST and DONE; burst_req in those states SHALL be ignored without setting burst_err.
REQ-018 Full throughput: with rd_ready held at 1, BURST_LEN words SHALL transfer in BURST_LEN consecutive cycles.
REQ-019 The accepted-write counter SHALL be 32 bits and saturate; wr_finish SHALL set on the cycle after the counter reaches TOTAL_WORDS.
REQ-020 flush SHALL take priority over all other inputs: pointers, count, remaining, rd_valid and sticky flags SHALL clear, the FSM SHALL go to IDLE, and memory contents are don't-care.

Reset
REQ-021 On rst_n low, all registers SHALL clear asynchronously: FSM IDLE, count 0, rd_valid 0, rd_data 0, burst_busy 0, burst_done 0, and all sticky flags 0; empty and prog_empty SHALL read 1.
REQ-022 Reset during BURST SHALL abort the burst with no burst_done.

Structure
REQ-023 Package sd_fifo_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-024 Storage SHALL be one sub-module, sdp_ram: simple dual-port, synchronous registered read, no reset on the array.

Verification
REQ-025 Write 256 words 0..255; pulse burst_req; hold rd_ready=1 -> rd_data 0..255 on 256 consecutive cycles, then burst_done, then count=0 and empty=1.
REQ-026 Fill 300 words, then burst with rd_ready toggling 1,0 -> no duplicated or lost word, rd_data held while stalled, count=44 at end.
REQ-027 Write 513 words -> full=1, overflow=1, count=512, prog_full=1.
REQ-028 With 100 words stored, pulse burst_req -> burst_err=1, burst_busy stays 0.
REQ-029 Write and read concurrently around pointer wrap (600 words total) -> ordered data, count stable at a steady level.
REQ-030 Assert rst_n=0 mid-burst, then separately assert flush mid-burst -> all outputs return to reset values, with no burst_done pulse.
